// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit: multi-cycle restoring divider for the ALU's DIV/MOD path.
// Each cycle does one trial subtract, computed as an add of the complement.
// Start/busy/done handshake. The result is held until the next accepted start.
// Optional build macro: DIV_SIGNED_EN selects two's-complement operands. The
// datapath divides magnitudes and fixes up the signs when it enters DONE.
module seq_divider_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH+1:0] SUM_ONE  = (WIDTH + 2)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;         // dividend shift register, fills with quotient bits
    logic [WIDTH-1:0] d_q, d_d;         // captured divisor (magnitude)
    logic [WIDTH:0]   r_q, r_d;         // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    // Iteration datapath signals.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH+1:0] sum;
    logic             no_borrow;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] a_mag, b_mag;

    // The remainder's top bit is always zero after a restore. Only the lower
    // bits feed the next shift and the result.
    logic unused_bits;
    assign unused_bits = r_q[WIDTH] ^ r_next[WIDTH];

`ifdef DIV_SIGNED_EN
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    logic neg_quot_q, neg_quot_d;
    logic neg_rem_q, neg_rem_d;
`endif

    // One restoring step. T = R' + ~D + 1 at WIDTH+1 bits. A carry out means no borrow.
    always_comb begin
        r_shift   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        sum       = {1'b0, r_shift} + {1'b0, ~{1'b0, d_q}} + SUM_ONE;
        no_borrow = sum[WIDTH+1];
        r_next    = no_borrow ? sum[WIDTH:0] : r_shift;
        q_next    = {q_q[WIDTH-2:0], no_borrow};
`ifdef DIV_SIGNED_EN
        a_mag = Dividend[WIDTH-1] ? (~Dividend + ONE) : Dividend;
        b_mag = Divisor[WIDTH-1]  ? (~Divisor + ONE)  : Divisor;
`else
        a_mag = Dividend;
        b_mag = Divisor;
`endif
    end

    // Next-state and register-load decisions for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    q_d   = a_mag;
                    d_d   = b_mag;
                    r_d   = '0;
                    cnt_d = '0;
`ifdef DIV_SIGNED_EN
                    neg_quot_d = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
                    neg_rem_d  = Dividend[WIDTH-1];
`endif
                    if (Divisor == '0) begin
                        // Zero divisor skips iterating. The result is fixed.
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                q_d   = q_next;
                r_d   = r_next;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    // Two's-complement negate. Most-negative / -1 wraps back to most-negative.
                    quot_d = neg_quot_q ? (~q_next + ONE) : q_next;
                    rem_d  = neg_rem_q ? (~r_next[WIDTH-1:0] + ONE) : r_next[WIDTH-1:0];
`else
                    quot_d = q_next;
                    rem_d  = r_next[WIDTH-1:0];
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset discards any in-flight division.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign Quotient    = quot_q;
    assign Remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Directed bench for seq_divider_8bit with hand-computed quotients and remainders.
module tb_seq_divider_8bit;

    logic       CLK = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] Dividend, Divisor, Quotient, Remainder;
    logic       busy, done, div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .CLK(CLK), .reset(reset), .start(start),
        .Dividend(Dividend), .Divisor(Divisor),
        .Quotient(Quotient), .Remainder(Remainder),
        .busy(busy), .done(done), .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Present operands with start. Return 1 time unit after the accepting edge.
    task automatic go(input logic [7:0] a, input logic [7:0] b, input bit hold);
        Dividend = a;
        Divisor  = b;
        start    = 1'b1;
        @(posedge CLK); #1;
        if (!hold) start = 1'b0;
    endtask

    // Count edges after acceptance until done, and count busy-high cycles. Bounded.
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (1) begin
            if (busy) bcnt++;
            if (done || cyc >= 20) break;
            @(posedge CLK); #1;
            cyc++;
        end
    endtask

    task automatic div_case(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic ez,
                            input int elat);
        int cyc, bcnt;
        go(a, b, 1'b0);
        wait_done(cyc, bcnt);
        chk({tag, "_lat"}, cyc, elat);
        chk({tag, "_busy_cyc"}, bcnt, elat + 1);
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_q"}, Quotient, eq);
        chk({tag, "_r"}, Remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ez);
        @(posedge CLK); #1;
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_q_held"}, Quotient, eq);
        chk({tag, "_r_held"}, Remainder, er);
    endtask

    initial begin
        int cyc, bcnt;
        reset = 1'b1; start = 1'b0; Dividend = '0; Divisor = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_q", Quotient, 8'h00);
        chk("rst_r", Remainder, 8'h00);
        chk("rst_dbz", div_by_zero, 1'b0);
        reset = 1'b0;

        // Divide by zero, then a normal divide that must clear div_by_zero.
        div_case("dz", 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 0);
        div_case("d9_3", 8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8);

        // Leave div-by-zero results in place, then reset in the middle of a run.
        div_case("dz2", 8'h5A, 8'h00, 8'hFF, 8'h5A, 1'b1, 0);
        go(8'd100, 8'd7, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_q", Quotient, 8'h00);
        chk("mid_rst_r", Remainder, 8'h00);
        chk("mid_rst_dbz", div_by_zero, 1'b0);
        @(posedge CLK); #1;
        reset = 1'b0;
        chk("mid_rst_busy2", busy, 1'b0);

        div_case("d100_7", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 8);
        div_case("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8);
        div_case("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8);
        div_case("d200_200", 8'd200, 8'd200, 8'd1, 8'd0, 1'b0, 8);
        div_case("d0_3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0, 8);

        // Hold start high and change operands after acceptance.
        go(8'd100, 8'd7, 1'b1);
        Dividend = 8'd50;
        Divisor  = 8'd5;
        wait_done(cyc, bcnt);
        chk("hold_lat", cyc, 8);
        chk("hold_q", Quotient, 8'd14);
        chk("hold_r", Remainder, 8'd2);
        @(posedge CLK); #1;
        chk("hold_done_ignored", busy, 1'b0);
        @(posedge CLK); #1;
        chk("hold_reaccept", busy, 1'b1);
        chk("hold_q_stable", Quotient, 8'd14);
        start = 1'b0;
        wait_done(cyc, bcnt);
        chk("hold2_lat", cyc, 8);
        chk("hold2_q", Quotient, 8'd10);
        chk("hold2_r", Remainder, 8'd0);
        @(posedge CLK); #1;

`ifdef DIV_SIGNED_EN
        div_case("s_m100_7", 8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 8);
        div_case("s_100_m7", 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 8);
        div_case("s_min_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 8);
`else
        div_case("u_156_7", 8'h9C, 8'h07, 8'd22, 8'd2, 1'b0, 8);
        div_case("u_100_249", 8'd100, 8'hF9, 8'd0, 8'd100, 1'b0, 8);
        div_case("u_128_255", 8'h80, 8'hFF, 8'd0, 8'h80, 1'b0, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider_8bit.md
Name: seq_divider_8bit

Overview:
Multi-cycle unsigned restoring divider, the inverse datapath to the team's carry-lookahead adder. It sits beside the ALU and is used for DIV/MOD instructions. Each iteration performs one subtract-as-add-of-complement (carry-in 1, borrow = NOT carry-out). The ALU drives a start/busy/done handshake and holds the result until the next start.

Parameters:
WIDTH, 8, operand/result width in bits; iteration count per division.

Ports:
CLK  input  1  clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a division; sampled only in IDLE.
Dividend  input  WIDTH  numerator; captured on the accepting edge.
Divisor  input  WIDTH  denominator; captured on the accepting edge.
Quotient  output  WIDTH  result quotient; held until next accepted start.
Remainder  output  WIDTH  result remainder; held until next accepted start.
busy  output  1  high when state != IDLE.
done  output  1  one-cycle pulse, high in DONE state.
div_by_zero  output  1  high with done when captured Divisor == 0; held with results.

Behaviour:
- One clock domain, CLK. Reset is synchronous and active-high.
- Reset (any state, including mid-RUN): state=IDLE; Quotient=0, Remainder=0, busy=0, done=0, div_by_zero=0; internal registers cleared; in-flight operation discarded.
- States:
  - IDLE -> RUN on start=1 when Divisor!=0.
  - IDLE -> DONE on start=1 when Divisor==0.
  - RUN -> DONE after the WIDTH-th iteration edge.
  - DONE -> IDLE unconditionally.
- start is ignored in RUN and DONE: no queuing, no restart.
- Accepting edge E0: latch Dividend into shift register Q, Divisor into D; set partial remainder R (WIDTH+1 bits) to 0 and iteration counter to 0.
- RUN iteration, one per edge:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - T = R' - D, computed as R' + ~D + 1 at WIDTH+1 bits.
  - If no borrow: R = T and shift 1 into Q LSB. Otherwise: R = R' and shift 0 into Q LSB.
  - Counter increments; on counter == WIDTH-1 the same edge moves to DONE and loads Quotient=Q_next, Remainder=R_next[WIDTH-1:0].
- Latency:
  - Nonzero divisor: done visible in the cycle after edge E0+WIDTH, i.e. WIDTH cycles of busy in RUN plus 1 in DONE.
  - Zero divisor: done visible in the cycle after E0 (busy high 1 cycle).
- Divide by zero: Quotient = all ones, Remainder = Dividend, div_by_zero=1.
- Quotient, Remainder and div_by_zero change only on entry to DONE or on reset. Values are stable through IDLE.
- div_by_zero is cleared on entry to DONE for a nonzero divisor.
- Back-to-back: start asserted in the DONE cycle is ignored. The earliest next acceptance is the cycle after done.
- Inputs Dividend/Divisor may change freely after E0.

Optional Feature:
Macro DIV_SIGNED_EN.
- Defined: operands are two's complement. The unit divides magnitudes and applies signs on entry to DONE: quotient sign = sign(Dividend) XOR sign(Divisor), remainder sign = sign(Dividend).
- Most-negative / -1 (e.g. 0x80/0xFF at WIDTH=8) yields Quotient=0x80, Remainder=0 (wraps).
- Divide by zero is unchanged: Quotient all ones, Remainder = Dividend.
- Latency is identical to the unsigned build.
- Not defined: purely unsigned; no sign logic synthesized.

Test Plan:
1. reset held 2 cycles mid-RUN (start 100/7, reset at iteration 4) -> next cycle busy=0, done=0, Quotient=0, Remainder=0; then 100/7 -> Quotient=14, Remainder=2.
2. start Dividend=100, Divisor=7 at E0 -> busy high 9 cycles; done pulses exactly 1 cycle, WIDTH edges after E0; Quotient=0x0E, Remainder=0x02, div_by_zero=0.
3. 255/1 -> Q=255,R=0. 5/9 -> Q=0,R=5. 200/200 -> Q=1,R=0. 0/3 -> Q=0,R=0. Each with 8-cycle latency.
4. Divisor=0, Dividend=0x5A -> done the cycle after E0; Quotient=0xFF, Remainder=0x5A, div_by_zero=1. A following 9/3 gives Q=3, R=0, div_by_zero=0.
5. start held high continuously with changing operands -> only operands present at each IDLE acceptance are used; start in RUN and DONE is ignored; results are unchanged until the next DONE.
6. DIV_SIGNED_EN defined:
   - -100/7 (0x9C/0x07) -> Q=0xF2 (-14), R=0xFE (-2).
   - 100/-7 -> Q=0xF2, R=0x02.
   - 0x80/0xFF -> Q=0x80, R=0x00.
